// File: rtl/me_search_ctrl_if.sv
// Bundle between the ME sequencer, the frame-buffer read ports and the PE array.
// Ports: start, sad_in (to ctrl); tb_addr, sw_addr, en_tb, en_sw, busy, done,
// min_sad, mv_x, mv_y (from ctrl). master = sequencer side, slave = environment.
interface me_search_ctrl_if #(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 6,
    parameter int TB_AW     = 8,
    parameter int SW_AW     = 12
);
    logic                 start;
    logic [TB_AW-1:0]     tb_addr;
    logic [SW_AW-1:0]     sw_addr;
    logic                 en_tb;
    logic                 en_sw;
    logic [SAD_WIDTH-1:0] sad_in;
    logic                 busy;
    logic                 done;
    logic [SAD_WIDTH-1:0] min_sad;
    logic [MV_WIDTH-1:0]  mv_x;
    logic [MV_WIDTH-1:0]  mv_y;

    modport master (
        input  start, sad_in,
        output tb_addr, sw_addr, en_tb, en_sw,
        output busy, done, min_sad, mv_x, mv_y
    );

    modport slave (
        output start, sad_in,
        input  tb_addr, sw_addr, en_tb, en_sw,
        input  busy, done, min_sad, mv_x, mv_y
    );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search ME sequencer: loads the template, streams the search window,
// samples SADs at candidate positions and keeps the best motion vector.
// Ports: clk, rst_n (sync, active low); bus (master) carries start/sad_in in,
// tb_addr/sw_addr/en_tb/en_sw to memories and array, busy/done/min_sad/mv out.
module me_search_ctrl #(
    parameter int TB_LENGTH   = 16,
    parameter int SW_LENGTH   = 48,
    parameter int SAD_WIDTH   = 16,
    parameter int SAD_LATENCY = 2,
    parameter int MV_WIDTH    = 6,
    parameter int TB_AW       = 8,
    parameter int SW_AW       = 12
) (
    input logic clk,
    input logic rst_n,
    me_search_ctrl_if.master bus
);
    localparam int TB_N = TB_LENGTH * TB_LENGTH;
    localparam int SW_N = SW_LENGTH * SW_LENGTH;
    localparam int CW   = $clog2(SW_LENGTH);
    localparam int DW   = $clog2(SAD_LATENCY + 2);

    localparam logic [TB_AW-1:0] TB_LAST = TB_AW'(TB_N - 1);
    localparam logic [SW_AW-1:0] SW_LAST = SW_AW'(SW_N - 1);
    localparam logic [CW-1:0]    C_LAST  = CW'(SW_LENGTH - 1);
    localparam logic [CW-1:0]    T_EDGE  = CW'(TB_LENGTH - 1);
    localparam logic [DW-1:0]    D_LAST  = DW'(SAD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TB,
        STREAM_SW,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TB_AW-1:0]     tb_cnt;
    logic [SW_AW-1:0]     sw_cnt;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic [DW-1:0]        drain_cnt;
    logic                 en_tb_q;
    logic                 en_sw_q;

    logic [SAD_LATENCY:0]               tag_v;
    logic [SAD_LATENCY:0][MV_WIDTH-1:0] tag_x;
    logic [SAD_LATENCY:0][MV_WIDTH-1:0] tag_y;

    logic [SAD_WIDTH-1:0] work_min;
    logic [MV_WIDTH-1:0]  work_x;
    logic [MV_WIDTH-1:0]  work_y;
    logic [SAD_WIDTH-1:0] pub_min;
    logic [MV_WIDTH-1:0]  pub_x;
    logic [MV_WIDTH-1:0]  pub_y;

    logic                 tb_last;
    logic                 sw_last;
    logic                 drain_last;
    logic                 cand;
    logic [CW-1:0]        dx;
    logic [CW-1:0]        dy;
    logic                 sample;

    assign tb_last    = (tb_cnt == TB_LAST);
    assign sw_last    = (sw_cnt == SW_LAST);
    assign drain_last = (drain_cnt == D_LAST);

    // The pixel issued this cycle closes a candidate once a full
    // template-sized window lies above and to the left of it.
    assign cand = (state == STREAM_SW)
               && (row >= T_EDGE) && (col >= T_EDGE);
    assign dx   = col - T_EDGE;
    assign dy   = row - T_EDGE;

    assign sample = tag_v[SAD_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.start)  state_nx = LOAD_TB;
            LOAD_TB:   if (tb_last)    state_nx = STREAM_SW;
            STREAM_SW: if (sw_last)    state_nx = DRAIN;
            DRAIN:     if (drain_last) state_nx = DONE;
            DONE:                      state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tb_cnt    <= '0;
            sw_cnt    <= '0;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
            en_tb_q   <= 1'b0;
            en_sw_q   <= 1'b0;
            tag_v     <= '0;
            tag_x     <= '0;
            tag_y     <= '0;
            work_min  <= '1;
            work_x    <= '0;
            work_y    <= '0;
            pub_min   <= '1;
            pub_x     <= '0;
            pub_y     <= '0;
        end else begin
            // Read data lands one cycle after the address, so the
            // shift enables are registered copies of the issue phase.
            en_tb_q <= (state == LOAD_TB);
            en_sw_q <= (state == STREAM_SW);

            tag_v[0] <= cand;
            tag_x[0] <= MV_WIDTH'(dx);
            tag_y[0] <= MV_WIDTH'(dy);
            for (int i = 1; i <= SAD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_x[i] <= tag_x[i-1];
                tag_y[i] <= tag_y[i-1];
            end

            if (state == LOAD_TB) begin
                tb_cnt <= tb_last ? '0 : tb_cnt + 1'b1;
            end

            if (state == STREAM_SW) begin
                if (sw_last) begin
                    sw_cnt <= '0;
                    row    <= '0;
                    col    <= '0;
                end else begin
                    sw_cnt <= sw_cnt + 1'b1;
                    if (col == C_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
            end

            // Strict compare: on ties the earliest raster candidate wins.
            if (state == IDLE) begin
                work_min <= '1;
                work_x   <= '0;
                work_y   <= '0;
            end else if (sample && (bus.sad_in < work_min)) begin
                work_min <= bus.sad_in;
                work_x   <= tag_x[SAD_LATENCY];
                work_y   <= tag_y[SAD_LATENCY];
            end

            if (state == DONE) begin
                pub_min <= work_min;
                pub_x   <= work_x;
                pub_y   <= work_y;
            end
        end
    end

    assign bus.tb_addr = tb_cnt;
    assign bus.sw_addr = sw_cnt;
    assign bus.en_tb   = en_tb_q;
    assign bus.en_sw   = en_sw_q;
    assign bus.busy    = (state != IDLE) && (state != DONE);
    assign bus.done    = (state == DONE);

    // During DONE the fresh result is forwarded so it is valid with done.
    assign bus.min_sad = bus.done ? work_min : pub_min;
    assign bus.mv_x    = bus.done ? work_x   : pub_x;
    assign bus.mv_y    = bus.done ? work_y   : pub_y;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: behavioural memories and PE array, table of
// search vectors, scoreboard of expected results, reset/restart sequences.
module tb_me_search_ctrl;
    localparam int TBL  = 16;
    localparam int SWL  = 48;
    localparam int SADW = 16;
    localparam int LAT  = 2;
    localparam int MVW  = 6;
    localparam int TBAW = 8;
    localparam int SWAW = 12;
    localparam int TBN  = TBL * TBL;
    localparam int SWN  = SWL * SWL;
    localparam int NC   = SWL - TBL + 1;
    localparam int LATENCY = TBN + SWN + LAT + 2;

    typedef struct {
        int tb_kind;
        int tb_val;
        int sw_kind;
        int sw_val;
        int ox;
        int oy;
        bit use_model;
        int e_min;
        int e_x;
        int e_y;
    } vec_t;

    typedef struct {
        int min;
        int x;
        int y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    me_search_ctrl_if #(
        .SAD_WIDTH(SADW), .MV_WIDTH(MVW),
        .TB_AW(TBAW), .SW_AW(SWAW)
    ) bus ();

    me_search_ctrl #(
        .TB_LENGTH(TBL), .SW_LENGTH(SWL), .SAD_WIDTH(SADW),
        .SAD_LATENCY(LAT), .MV_WIDTH(MVW),
        .TB_AW(TBAW), .SW_AW(SWAW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0] tb_mem [TBN];
    logic [7:0] sw_mem [SWN];

    // ---- memory + PE array model ----
    logic [TBAW-1:0] tb_addr_q;
    logic [SWAW-1:0] sw_addr_q;
    logic            en_tb_p, en_sw_p;
    int              tb_idx, sw_idx, ti_use, si_use;
    logic [7:0]      rx_tb [TBN];
    logic [7:0]      rx_sw [SWN];
    logic            t1_v;
    int              t1_r, t1_c;
    logic [SADW-1:0] sad_q;
    int              cand_cnt = 0;
    int              tb_err = 0;
    int              sw_err = 0;

    assign bus.sad_in = sad_q;

    always_comb begin
        ti_use = tb_idx;
        si_use = sw_idx;
        if (bus.en_tb && !en_tb_p) ti_use = 0;
        if (bus.en_sw && !en_sw_p) si_use = 0;
    end

    function automatic int win_sad(int r, int c);
        int s = 0;
        for (int i = 0; i < TBL; i++) begin
            for (int j = 0; j < TBL; j++) begin
                int a = int'(rx_sw[(r - TBL + 1 + i) * SWL + (c - TBL + 1 + j)]);
                int b = int'(rx_tb[i * TBL + j]);
                s += (a > b) ? a - b : b - a;
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        tb_addr_q <= bus.tb_addr;
        sw_addr_q <= bus.sw_addr;
        if (!rst_n) begin
            en_tb_p <= 1'b0;
            en_sw_p <= 1'b0;
            tb_idx  <= 0;
            sw_idx  <= 0;
            t1_v    <= 1'b0;
            sad_q   <= '0;
        end else begin
            en_tb_p <= bus.en_tb;
            en_sw_p <= bus.en_sw;
            t1_v    <= 1'b0;
            if (bus.en_tb) begin
                if (ti_use < TBN) rx_tb[ti_use] <= tb_mem[tb_addr_q];
                if (int'(tb_addr_q) != ti_use) tb_err <= tb_err + 1;
                tb_idx <= ti_use + 1;
            end
            if (bus.en_sw) begin
                if (si_use < SWN) rx_sw[si_use] <= sw_mem[sw_addr_q];
                if (int'(sw_addr_q) != si_use) sw_err <= sw_err + 1;
                sw_idx <= si_use + 1;
                if (si_use < SWN && si_use / SWL >= TBL - 1
                    && si_use % SWL >= TBL - 1) begin
                    t1_v     <= 1'b1;
                    t1_r     <= si_use / SWL;
                    t1_c     <= si_use % SWL;
                    cand_cnt <= cand_cnt + 1;
                end
            end
            // Off-candidate cycles carry small junk so wrong sampling shows.
            sad_q <= t1_v ? SADW'(win_sad(t1_r, t1_c))
                          : SADW'($urandom_range(0, 3));
        end
    end

    // ---- activity monitor ----
    int cyc = 0;
    int en_tb_n = 0;
    int en_sw_n = 0;
    int viol_n = 0;
    int done_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.en_tb) en_tb_n <= en_tb_n + 1;
        if (bus.en_sw) en_sw_n <= en_sw_n + 1;
        if ((bus.en_tb || bus.en_sw) && !bus.busy) viol_n <= viol_n + 1;
        if (bus.done) done_n <= done_n + 1;
    end

    // ---- checking ----
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic ref_search(output exp_t e);
        e.min = 65535;
        e.x = 0;
        e.y = 0;
        for (int y = 0; y < NC; y++) begin
            for (int x = 0; x < NC; x++) begin
                int s = 0;
                for (int i = 0; i < TBL; i++) begin
                    for (int j = 0; j < TBL; j++) begin
                        int a = int'(sw_mem[(y + i) * SWL + x + j]);
                        int b = int'(tb_mem[i * TBL + j]);
                        s += (a > b) ? a - b : b - a;
                    end
                end
                if (s < e.min) begin
                    e.min = s;
                    e.x = x;
                    e.y = y;
                end
            end
        end
    endtask

    task automatic setup(input vec_t v, output exp_t e);
        if (v.sw_kind == 0) begin
            for (int i = 0; i < SWN; i++) sw_mem[i] = 8'(v.sw_val);
        end else begin
            for (int i = 0; i < SWN; i++) sw_mem[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < TBL; i++) begin
            for (int j = 0; j < TBL; j++) begin
                tb_mem[i * TBL + j] = (v.tb_kind == 0) ? 8'(v.tb_val)
                    : sw_mem[(v.oy + i) * SWL + v.ox + j];
            end
        end
        if (v.tb_kind == 2) tb_mem[37] = tb_mem[37] ^ 8'h01;
        if (v.use_model) begin
            ref_search(e);
        end else begin
            e.min = v.e_min;
            e.x = v.e_x;
            e.y = v.e_y;
        end
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int t0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < LATENCY + 200; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, int'(ok), 1);
        if (ok) chk({nm, "_latency"}, cyc - t0, LATENCY);
    endtask

    task automatic check_result(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_scoreboard_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_min_sad"}, int'(bus.min_sad), e.min);
            chk({nm, "_mv_x"}, int'(bus.mv_x), e.x);
            chk({nm, "_mv_y"}, int'(bus.mv_y), e.y);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        exp_t e;
        int   s_tb, s_sw, s_c, s_te, s_se, s_v, s_d, t0;
        bit   ok;
        setup(v, e);
        sb.push_back(e);
        s_tb = en_tb_n;
        s_sw = en_sw_n;
        s_c  = cand_cnt;
        s_te = tb_err;
        s_se = sw_err;
        s_v  = viol_n;
        s_d  = done_n;
        pulse_start(t0);
        wait_done(nm, t0, ok);
        if (ok) check_result(nm);
        repeat (5) @(negedge clk);
        chk({nm, "_hold_min_sad"}, int'(bus.min_sad), e.min);
        chk({nm, "_hold_mv"}, int'({bus.mv_y, bus.mv_x}), (e.y << MVW) | e.x);
        chk({nm, "_busy_after"}, int'(bus.busy), 0);
        chk({nm, "_en_tb_cycles"}, en_tb_n - s_tb, TBN);
        chk({nm, "_en_sw_cycles"}, en_sw_n - s_sw, SWN);
        chk({nm, "_candidates"}, cand_cnt - s_c, NC * NC);
        chk({nm, "_addr_order"}, (tb_err - s_te) + (sw_err - s_se), 0);
        chk({nm, "_en_outside"}, viol_n - s_v, 0);
        chk({nm, "_done_pulses"}, done_n - s_d, 1);
    endtask

    initial begin
        exp_t e;
        int   t0, s_d;
        bit   ok;

        //          tbk tbv swk swv ox  oy  model min    x   y
        vecs[0] = '{0,  0,  0,  0,  0,  0,  1'b0, 0,     0,  0};
        vecs[1] = '{1,  0,  1,  0,  5,  9,  1'b0, 0,     5,  9};
        vecs[2] = '{0, 255, 0,  0,  0,  0,  1'b0, 65280, 0,  0};
        vecs[3] = '{1,  0,  1,  0,  32, 32, 1'b0, 0,     32, 32};
        vecs[4] = '{2,  0,  1,  0,  20, 3,  1'b1, 0,     0,  0};

        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_en_tb", int'(bus.en_tb), 0);
        chk("idle_en_sw", int'(bus.en_sw), 0);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);
        chk("idle_min_sad", int'(bus.min_sad), 16'hFFFF);
        chk("idle_mv", int'({bus.mv_y, bus.mv_x}), 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start re-pulsed mid-search and in the DONE cycle
        setup(vecs[4], e);
        sb.push_back(e);
        s_d = done_n;
        pulse_start(t0);
        repeat (99) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("restart", t0, ok);
        if (ok) begin
            bus.start = 1'b1;
            check_result("restart");
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        repeat (20) @(negedge clk);
        chk("restart_busy_after", int'(bus.busy), 0);
        chk("restart_done_pulses", done_n - s_d, 1);

        // reset in the middle of a search
        setup(vecs[1], e);
        sb.push_back(e);
        s_d = done_n;
        pulse_start(t0);
        repeat (1499) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_en", int'({bus.en_tb, bus.en_sw}), 0);
        chk("abort_min_sad", int'(bus.min_sad), 16'hFFFF);
        rst_n = 1'b1;
        if (sb.size() > 0) e = sb.pop_front();
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_n - s_d, 0);
        run_vec(vecs[3], "after_reset");

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Sequencer for the full-search motion-estimation datapath (PE array plus SAD adder tree).
- On a start pulse it:
  - fetches the template block (TB) from TB memory into the array,
  - streams the whole search window (SW) in raster order,
  - samples the SAD stream only at valid candidate positions,
  - tracks the minimum SAD and its motion vector, then pulses done.
- Sits between the frame-buffer read ports and the PE array. Memory read data goes straight to the array; this block drives only the addresses and enables.

Parameters:
- TB_LENGTH, 16, template block edge in pixels.
- SW_LENGTH, 48, search window edge in pixels.
- SAD_WIDTH, 16, SAD width; must hold 255*TB_LENGTH^2.
- SAD_LATENCY, 2, cycles from the en_sw cycle that shifts in a candidate's last pixel to that candidate's SAD on sad_in.
- MV_WIDTH, 6, width of each motion-vector component; must hold SW_LENGTH-TB_LENGTH.
- TB_AW, 8, TB address width, log2(TB_LENGTH^2).
- SW_AW, 12, SW address width, ceil(log2(SW_LENGTH^2)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a search
- tb_addr  out  TB_AW  TB memory read address
- sw_addr  out  SW_AW  SW memory read address
- en_tb  out  1  TB shift enable to the PE array
- en_sw  out  1  SW shift enable to the PE array
- sad_in  in  SAD_WIDTH  SAD output of the array
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse; results valid
- min_sad  out  SAD_WIDTH  minimum SAD of the last search
- mv_x  out  MV_WIDTH  column offset of the best candidate, 0..SW_LENGTH-TB_LENGTH
- mv_y  out  MV_WIDTH  row offset of the best candidate

Behaviour:
- Reset (rst_n low at a clock edge):
  - state IDLE; all outputs 0, except min_sad which is all ones.
  - Reset mid-search aborts immediately; no done pulse.
- Memory read latency is 1 cycle. An address issued in cycle t yields data in t+1, and the matching en_tb/en_sw is asserted in t+1 (a registered copy of the address-valid flag).
- FSM states:
  - IDLE: start=1 moves to LOAD_TB. Clears the working minimum to all ones and the best MV to 0. Keeps the published min_sad/mv until done.
  - LOAD_TB: issue tb_addr 0..TB_LENGTH^2-1, one per cycle, then go to STREAM_SW. busy=1.
  - STREAM_SW: issue sw_addr 0..SW_LENGTH^2-1 in raster order, one per cycle. Row counter r and column counter c advance with the address; c wraps at SW_LENGTH-1 and increments r. Then go to DRAIN.
  - DRAIN: wait SAD_LATENCY+1 cycles for the pipeline to empty, then go to DONE.
  - DONE: for one cycle, publish min_sad/mv_x/mv_y, pulse done=1, drop busy, return to IDLE.
- There is no gap between the last tb_addr and the first sw_addr. The last en_tb and the first en_sw fall in the same cycle, which is legal.
- Candidate tagging:
  - A streamed pixel at (r,c) closes candidate (x,y)=(c-TB_LENGTH+1, r-TB_LENGTH+1) iff r>=TB_LENGTH-1 and c>=TB_LENGTH-1.
  - The tag (valid, x, y) is delayed through a SAD_LATENCY-deep pipe aligned with en_sw.
  - sad_in is sampled only when the delayed tag is valid.
  - Number of candidates = (SW_LENGTH-TB_LENGTH+1)^2, i.e. 1089 at defaults.
- Compare: update the working min and MV only if sad_in < working min (strict). Ties keep the earliest candidate in raster order.
- Timing: with start sampled in cycle 0, done is high in cycle TB_LENGTH^2+SW_LENGTH^2+SAD_LATENCY+2, which is 2564 at defaults.
- start handling: start while busy is ignored. start in the DONE cycle is also ignored; a new search needs start in IDLE.
- Published results hold until the next done.
- en_tb and en_sw are never asserted outside a search.

Test Plan:
- Reset, then idle 10 cycles -> en_tb=en_sw=busy=done=0, min_sad=16'hFFFF, mv=(0,0).
- start with TB all 0 and SW all 0, default params, real PE array -> done exactly 2564 cycles after start, min_sad=0, mv=(0,0) (tie keeps first). en_tb high for 256 cycles; en_sw high for 2304 cycles.
- SW random; TB copied from SW at offset (x=5, y=9), no other exact match -> min_sad=0, mv_x=5, mv_y=9. Count of sampled SADs = 1089.
- TB all 255, SW all 0 -> min_sad=65280, mv=(0,0). Then a second start with TB = SW region at (32,32) -> min_sad=0, mv=(32,32) (corner wrap-around of the counters).
- start re-pulsed at cycles 100 and 2564 of a running search -> both ignored; exactly one done, at cycle 2564.
- rst_n low at cycle 1500 of a search -> next cycle state IDLE, busy=0, no done; a subsequent start completes normally with correct results.
